// File: rtl/bht_update_arbiter_if.sv
// Decode-control type shared with the EX stages, plus the arbiter's bus
// interface. The struct carries only the fields the BHT training path reads.
package isa_pkg;
  typedef struct packed {
    logic       is_branch;  // instruction is a branch/jump-class op
    logic [2:0] funct3;     // 011 = JAL, 010 = JALR, others = conditional
  } decode_ctrl_t;
endpackage

// Bundles both resolve sources, the control inputs and the BHT update port.
// master = EX side (drives sources, hold, flush); slave = the arbiter.
interface bht_update_arbiter_if #(
  parameter int DEPTH = 4
);
  import isa_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);

  logic         s0_valid;
  logic         s0_ready;
  decode_ctrl_t s0_ctrl;
  logic [31:0]  s0_pc;
  logic         s0_taken;

  logic         s1_valid;
  logic         s1_ready;
  decode_ctrl_t s1_ctrl;
  logic [31:0]  s1_pc;
  logic         s1_taken;

  logic         hold;
  logic         flush;

  logic         update_valid;
  decode_ctrl_t update_ctrl;
  logic [31:0]  update_pc;
  logic         update_taken;

  logic [CW-1:0] q0_count;
  logic [CW-1:0] q1_count;
  logic          busy;

  modport master (
    output s0_valid, s0_ctrl, s0_pc, s0_taken,
    output s1_valid, s1_ctrl, s1_pc, s1_taken,
    output hold, flush,
    input  s0_ready, s1_ready,
    input  update_valid, update_ctrl, update_pc, update_taken,
    input  q0_count, q1_count, busy
  );

  modport slave (
    input  s0_valid, s0_ctrl, s0_pc, s0_taken,
    input  s1_valid, s1_ctrl, s1_pc, s1_taken,
    input  hold, flush,
    output s0_ready, s1_ready,
    output update_valid, update_ctrl, update_pc, update_taken,
    output q0_count, q1_count, busy
  );
endinterface

// File: rtl/bht_update_arbiter.sv
// Funnels resolved conditional branches from two EX sources into the single
// BHT update port. Each source owns a small FIFO; heads are served round-robin,
// one update per cycle. JAL/JALR and non-branches are accepted but dropped.
module bht_update_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bht_update_arbiter_if.slave   bus
);
  import isa_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    decode_ctrl_t ctrl;
    logic [31:0]  pc;
    logic         taken;
  } entry_t;

  // Per-source views so both FIFOs can be built by one generate loop.
  logic          s_valid  [2];
  decode_ctrl_t  s_ctrl   [2];
  logic [31:0]   s_pc     [2];
  logic          s_taken  [2];
  logic          s_ready  [2];
  logic          is_cond  [2];
  logic          push     [2];
  logic          pop      [2];
  logic          nonempty [2];
  logic [CW-1:0] count    [2];
  entry_t        head     [2];

  logic rr_q, rr_d;
  logic grant;
  logic any_ne;
  logic can_pop;

  assign s_valid[0] = bus.s0_valid;
  assign s_ctrl[0]  = bus.s0_ctrl;
  assign s_pc[0]    = bus.s0_pc;
  assign s_taken[0] = bus.s0_taken;
  assign s_valid[1] = bus.s1_valid;
  assign s_ctrl[1]  = bus.s1_ctrl;
  assign s_pc[1]    = bus.s1_pc;
  assign s_taken[1] = bus.s1_taken;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      entry_t        mem_q [DEPTH];
      logic [PW-1:0] wr_ptr_q, wr_ptr_d;
      logic [PW-1:0] rd_ptr_q, rd_ptr_d;
      logic [CW-1:0] count_q, count_d;

      // Only conditional branches train the BHT; jumps complete but are dropped.
      assign is_cond[gi]  = s_ctrl[gi].is_branch &&
                            (s_ctrl[gi].funct3 != 3'b011) &&
                            (s_ctrl[gi].funct3 != 3'b010);
      // Ready ignores a same-cycle pop so it never depends on the grant path.
      assign s_ready[gi]  = (count_q != CW'(DEPTH)) && !bus.flush;
      assign push[gi]     = s_valid[gi] && s_ready[gi] && is_cond[gi];
      assign nonempty[gi] = (count_q != '0);
      assign pop[gi]      = can_pop && nonempty[gi] && (grant == 1'(gi));
      assign count[gi]    = count_q;
      assign head[gi]     = mem_q[rd_ptr_q];

      // Pointer and occupancy next state; flush empties the FIFO.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
          case ({push[gi], pop[gi]})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end

      // FIFO control state register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage write; contents need no reset since count gates visibility.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_q[wr_ptr_q] <= '{ctrl: s_ctrl[gi], pc: s_pc[gi], taken: s_taken[gi]};
        end
      end
    end
  endgenerate

  // Round-robin grant: rr breaks ties, a lone non-empty source always wins,
  // and the pointer then favours the source that was not served.
  always_comb begin
    any_ne  = nonempty[0] || nonempty[1];
    can_pop = !bus.hold && !bus.flush;
    grant   = 1'b0;
    if (nonempty[0] && nonempty[1]) begin
      grant = rr_q;
    end else if (nonempty[1]) begin
      grant = 1'b1;
    end
    rr_d = rr_q;
    if (bus.flush) begin
      rr_d = 1'b0;
    end else if (can_pop && any_ne) begin
      rr_d = ~grant;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign bus.s0_ready     = s_ready[0];
  assign bus.s1_ready     = s_ready[1];
  assign bus.update_valid = can_pop && any_ne;
  assign bus.update_ctrl  = head[grant].ctrl;
  assign bus.update_pc    = head[grant].pc;
  assign bus.update_taken = head[grant].taken;
  assign bus.q0_count     = count[0];
  assign bus.q1_count     = count[1];
  assign bus.busy         = any_ne;

endmodule

// File: tb/tb_bht_update_arbiter.sv
// Randomised and directed bench for bht_update_arbiter. A queue-based model
// tracks what each source FIFO must hold and is compared every cycle.
module tb_bht_update_arbiter;
  import isa_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bht_update_arbiter_if #(.DEPTH(DEPTH)) bus ();

  bht_update_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]  pc;
    logic         taken;
    decode_ctrl_t ctrl;
  } upd_t;

  upd_t mq0[$];
  upd_t mq1[$];
  bit   mrr = 1'b0;

  int checks = 0;
  int failures = 0;

  function automatic bit cond_br(decode_ctrl_t c);
    return c.is_branch && (c.funct3 != 3'b011) && (c.funct3 != 3'b010);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are checked mid-cycle, then the model takes the
  // transition the coming rising edge will make.
  always @(negedge clk) begin : model
    int   n0, n1;
    bit   ev, win;
    upd_t h, e;
    n0  = mq0.size();
    n1  = mq1.size();
    ev  = !bus.hold && !bus.flush && (n0 + n1 > 0);
    win = (n0 > 0 && n1 > 0) ? mrr : (n0 > 0 ? 1'b0 : 1'b1);
    chk("m_ready0", 32'(bus.s0_ready), 32'((n0 != DEPTH) && !bus.flush));
    chk("m_ready1", 32'(bus.s1_ready), 32'((n1 != DEPTH) && !bus.flush));
    chk("m_q0_count", 32'(bus.q0_count), 32'(n0));
    chk("m_q1_count", 32'(bus.q1_count), 32'(n1));
    chk("m_busy", 32'(bus.busy), 32'(n0 + n1 > 0));
    chk("m_valid", 32'(bus.update_valid), 32'(ev));
    if (ev) begin
      h = win ? mq1[0] : mq0[0];
      chk("m_pc", bus.update_pc, h.pc);
      chk("m_taken", 32'(bus.update_taken), 32'(h.taken));
      chk("m_ctrl", {28'b0, bus.update_ctrl}, {28'b0, h.ctrl});
    end
    if (!rst_n || bus.flush) begin
      mq0.delete();
      mq1.delete();
      mrr = 1'b0;
    end else begin
      if (ev) begin
        if (win) void'(mq1.pop_front());
        else     void'(mq0.pop_front());
        mrr = ~win;
      end
      if (bus.s0_valid && n0 != DEPTH && cond_br(bus.s0_ctrl)) begin
        e.pc = bus.s0_pc; e.taken = bus.s0_taken; e.ctrl = bus.s0_ctrl;
        mq0.push_back(e);
      end
      if (bus.s1_valid && n1 != DEPTH && cond_br(bus.s1_ctrl)) begin
        e.pc = bus.s1_pc; e.taken = bus.s1_taken; e.ctrl = bus.s1_ctrl;
        mq1.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s0_valid = 1'b0; bus.s0_ctrl = '0; bus.s0_pc = '0; bus.s0_taken = 1'b0;
    bus.s1_valid = 1'b0; bus.s1_ctrl = '0; bus.s1_pc = '0; bus.s1_taken = 1'b0;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic drive(input int src, input logic br, input logic [2:0] f3,
                       input logic [31:0] pc, input logic tk);
    if (src == 0) begin
      bus.s0_valid = 1'b1; bus.s0_ctrl = '{is_branch: br, funct3: f3};
      bus.s0_pc = pc; bus.s0_taken = tk;
    end else begin
      bus.s1_valid = 1'b1; bus.s1_ctrl = '{is_branch: br, funct3: f3};
      bus.s1_pc = pc; bus.s1_taken = tk;
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // 1: reset state while idle
    step();
    #1;
    chk("t1_valid", 32'(bus.update_valid), 32'd0);
    chk("t1_ready0", 32'(bus.s0_ready), 32'd1);
    chk("t1_ready1", 32'(bus.s1_ready), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_q0", 32'(bus.q0_count), 32'd0);
    chk("t1_q1", 32'(bus.q1_count), 32'd0);

    // 2: single BEQ on s0 appears the next cycle and pops
    drive(0, 1'b1, 3'b000, 32'h100, 1'b1);
    step();
    idle();
    #1;
    chk("t2_valid", 32'(bus.update_valid), 32'd1);
    chk("t2_pc", bus.update_pc, 32'h100);
    chk("t2_taken", 32'(bus.update_taken), 32'd1);
    step();
    #1;
    chk("t2_q0_after", 32'(bus.q0_count), 32'd0);
    chk("t2_valid_after", 32'(bus.update_valid), 32'd0);

    // 3: reset rr, then two beats per source -> s0, s1, s0, s1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 1'b1, 3'b001, 32'h200, 1'b0);
    drive(1, 1'b1, 3'b100, 32'h300, 1'b1);
    step();
    drive(0, 1'b1, 3'b101, 32'h204, 1'b1);
    drive(1, 1'b1, 3'b110, 32'h304, 1'b0);
    #1;
    chk("t3_g0_valid", 32'(bus.update_valid), 32'd1);
    chk("t3_g0_pc", bus.update_pc, 32'h200);
    step();
    idle();
    #1;
    chk("t3_g1_pc", bus.update_pc, 32'h300);
    step();
    #1;
    chk("t3_g2_pc", bus.update_pc, 32'h204);
    step();
    #1;
    chk("t3_g3_valid", 32'(bus.update_valid), 32'd1);
    chk("t3_g3_pc", bus.update_pc, 32'h304);
    step();

    // 4: JAL and JALR on s1 handshake but never enqueue
    drive(1, 1'b1, 3'b011, 32'h500, 1'b1);
    #1;
    chk("t4_jal_ready", 32'(bus.s1_ready), 32'd1);
    step();
    drive(1, 1'b1, 3'b010, 32'h504, 1'b1);
    #1;
    chk("t4_jalr_ready", 32'(bus.s1_ready), 32'd1);
    step();
    idle();
    #1;
    chk("t4_valid", 32'(bus.update_valid), 32'd0);
    chk("t4_q1", 32'(bus.q1_count), 32'd0);

    // 5: fill s0 under hold, then drain in order
    for (int k = 0; k < DEPTH; k++) begin
      bus.hold = 1'b1;
      drive(0, 1'b1, 3'b000, 32'h400 + 32'(4 * k), k[0]);
      #1;
      chk("t5_ready_fill", 32'(bus.s0_ready), 32'd1);
      step();
    end
    idle();
    bus.hold = 1'b1;
    #1;
    chk("t5_q0_full", 32'(bus.q0_count), 32'(DEPTH));
    chk("t5_ready_full", 32'(bus.s0_ready), 32'd0);
    chk("t5_valid_hold", 32'(bus.update_valid), 32'd0);
    bus.hold = 1'b0;
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("t5_drain_valid", 32'(bus.update_valid), 32'd1);
      chk("t5_drain_pc", bus.update_pc, 32'h400 + 32'(4 * k));
      step();
      #1;
    end
    chk("t5_empty", 32'(bus.busy), 32'd0);

    // 6: fill both, then flush with a push attempt in the same cycle
    for (int k = 0; k < DEPTH; k++) begin
      bus.hold = 1'b1;
      drive(0, 1'b1, 3'b000, 32'h600 + 32'(4 * k), 1'b1);
      drive(1, 1'b1, 3'b001, 32'h700 + 32'(4 * k), 1'b0);
      step();
    end
    idle();
    bus.flush = 1'b1;
    drive(0, 1'b1, 3'b000, 32'h999, 1'b1);
    #1;
    chk("t6_flush_valid", 32'(bus.update_valid), 32'd0);
    chk("t6_flush_ready0", 32'(bus.s0_ready), 32'd0);
    chk("t6_flush_ready1", 32'(bus.s1_ready), 32'd0);
    chk("t6_busy_before", 32'(bus.busy), 32'd1);
    step();
    idle();
    #1;
    chk("t6_q0", 32'(bus.q0_count), 32'd0);
    chk("t6_q1", 32'(bus.q1_count), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_valid", 32'(bus.update_valid), 32'd0);

    // Random traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      bus.hold     = ($urandom_range(0, 3) == 0);
      bus.flush    = ($urandom_range(0, 24) == 0);
      bus.s0_valid = ($urandom_range(0, 9) < 6);
      bus.s0_ctrl  = '{is_branch: ($urandom_range(0, 3) != 0), funct3: 3'($urandom_range(0, 7))};
      bus.s0_pc    = $urandom & 32'hFFFF_FFFC;
      bus.s0_taken = 1'($urandom);
      bus.s1_valid = ($urandom_range(0, 9) < 6);
      bus.s1_ctrl  = '{is_branch: ($urandom_range(0, 3) != 0), funct3: 3'($urandom_range(0, 7))};
      bus.s1_pc    = $urandom & 32'hFFFF_FFFC;
      bus.s1_taken = 1'($urandom);
      step();
    end

    rst_n = 1'b1;
    idle();
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
